fixed_to_decimal: RTL and testbench



---
 rtl/calc_pkg.sv | 29 ++
 rtl/bcd_dd_lane.sv | 39 +++
 rtl/fixed_to_decimal.sv | 104 ++++++++++
 tb/tb_fixed_to_decimal.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator constants and types for the fixed-point to BCD converter.
// FIXED_TO_DECIMAL_ROUND_EN selects round-half-up of the fraction instead of truncation.
package calc_pkg;

  localparam int INT_W      = 10;
  localparam int FRAC_W     = 6;
  localparam int INT_DIGITS = 4;
  localparam int FIXED_W    = INT_W + FRAC_W;
  localparam int FRAC_DEC_W = 7;
  localparam int PROD_W     = FRAC_W + FRAC_DEC_W;

`ifdef FIXED_TO_DECIMAL_ROUND_EN
  localparam int RND = 2 ** (FRAC_W - 1);
`else
  localparam int RND = 0;
`endif

  typedef logic [FIXED_W-1:0] fixed_t;
  typedef logic [3:0]         bcd_digit_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Scale the binary fraction to hundredths: (f*100 + RND) / 2^FRAC_W, always 0..99.
  function automatic logic [FRAC_DEC_W-1:0] frac_to_dec(input logic [FRAC_W-1:0] f);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(f) * PROD_W'(100) + PROD_W'(RND);
    return prod[PROD_W-1:FRAC_W];
  endfunction

endpackage

// File: rtl/bcd_dd_lane.sv
// One shift-and-add-3 (double-dabble) lane: load a binary value, then one bit per step.
module bcd_dd_lane #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [BIN_W-1:0]    bin_reg;
  logic [4*DIGITS-1:0] bcd_reg;
  logic [4*DIGITS-1:0] bcd_adj;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                               : bcd_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg <= '0;
      bcd_reg <= '0;
    end else if (load) begin
      bin_reg <= bin;
      bcd_reg <= '0;
    end else if (step) begin
      {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
    end
  end

  assign bcd = bcd_reg;

endmodule

// File: rtl/fixed_to_decimal.sv
// Unsigned 10.6 fixed-point to BCD (four integer digits, tenths, hundredths), one bit per clock.
// Define FIXED_TO_DECIMAL_ROUND_EN to round the fraction to the nearest hundredth instead of truncating.
module fixed_to_decimal
  import calc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  fixed_t                  in_fixed,
  output logic                    busy,
  output logic                    done,
  output logic [4*INT_DIGITS-1:0] int_bcd,
  output bcd_digit_t              tenths,
  output bcd_digit_t              hundredths
);

  localparam int CNT_W = $clog2(INT_W);

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    accept;
  logic                    lane_step;
  logic [INT_W-1:0]        int_bin;
  logic [INT_W-1:0]        frac_bin;
  logic [4*INT_DIGITS-1:0] int_digits;
  logic [4*INT_DIGITS-1:0] frac_digits;
  logic                    unused_frac_hi;

  assign accept    = start && (state_reg != SHIFT);
  assign lane_step = (state_reg == SHIFT);
  assign int_bin   = in_fixed[FIXED_W-1:FRAC_W];
  assign frac_bin  = INT_W'(frac_to_dec(in_fixed[FRAC_W-1:0]));

  bcd_dd_lane #(.BIN_W(INT_W), .DIGITS(INT_DIGITS)) u_int_lane (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (lane_step),
    .bin   (int_bin),
    .bcd   (int_digits)
  );

  // Same shape as the integer lane; the fraction is below 100, so only the low two digits matter.
  bcd_dd_lane #(.BIN_W(INT_W), .DIGITS(INT_DIGITS)) u_frac_lane (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (lane_step),
    .bin   (frac_bin),
    .bcd   (frac_digits)
  );

  assign unused_frac_hi = ^frac_digits[4*INT_DIGITS-1:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      int_bcd    <= '0;
      tenths     <= '0;
      hundredths <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= SHIFT;
            cnt_reg   <= '0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_reg == CNT_W'(INT_W - 1)) begin
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // Lanes hold the finished result during this cycle; publish it as DONE is left.
          done       <= 1'b1;
          int_bcd    <= int_digits;
          tenths     <= frac_digits[7:4];
          hundredths <= frac_digits[3:0];
          if (start) begin
            state_reg <= SHIFT;
            cnt_reg   <= '0;
            busy      <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_decimal.sv
// Scoreboard bench for fixed_to_decimal: stimulus pushes expected digits and done cycle, monitor checks on done.
module tb_fixed_to_decimal;
  import calc_pkg::*;

`ifdef FIXED_TO_DECIMAL_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  fixed_t      in_fixed = '0;
  logic        busy;
  logic        done;
  logic [15:0] int_bcd;
  bcd_digit_t  tenths;
  bcd_digit_t  hundredths;

  fixed_to_decimal dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_fixed   (in_fixed),
    .busy       (busy),
    .done       (done),
    .int_bcd    (int_bcd),
    .tenths     (tenths),
    .hundredths (hundredths)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] ib;
    logic [3:0]  t;
    logic [3:0]  h;
    int          dcyc;
    logic        busy_after;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result, at the expected cycle.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("int_bcd", 32'(int_bcd), 32'(e.ib));
        check("tenths", 32'(tenths), 32'(e.t));
        check("hundredths", 32'(hundredths), 32'(e.h));
        check("done_cycle", 32'(cyc), 32'(e.dcyc));
        check("busy_at_done", 32'(busy), 32'(e.busy_after));
        $display("done: int=%04h frac=.%0d%0d at cycle %0d", int_bcd, tenths, hundredths, cyc);
      end
    end
  end

  function automatic exp_t mk(input logic [15:0] ib, input logic [3:0] tt, input logic [3:0] ht,
                              input logic [3:0] tr, input logic [3:0] hr, input int dcyc,
                              input logic b);
    exp_t e;
    e.ib = ib;
    e.t = ROUND ? tr : tt;
    e.h = ROUND ? hr : ht;
    e.dcyc = dcyc;
    e.busy_after = b;
    return e;
  endfunction

  task automatic issue(input fixed_t v, input logic [15:0] ib, input logic [3:0] tt,
                       input logic [3:0] ht, input logic [3:0] tr, input logic [3:0] hr);
    @(negedge clk);
    start = 1'b1;
    in_fixed = v;
    exp_q.push_back(mk(ib, tt, ht, tr, hr, cyc + 12, 1'b0));
    $display("start: in_fixed=%04h", v);
    @(negedge clk);
    start = 1'b0;
    in_fixed = fixed_t'($urandom);
    check("busy_after_accept", 32'(busy), 32'(1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (busy || exp_q.size() != 0); i++) @(negedge clk);
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_queue", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_int", 32'(int_bcd), 32'(0));
    check("rst_tenths", 32'(tenths), 32'(0));
    check("rst_hundredths", 32'(hundredths), 32'(0));
    rst_n = 1'b1;

    issue(16'h0170, 16'h0005, 4'd7, 4'd5, 4'd7, 4'd5);
    wait_idle();

    // Output hold across a new conversion; a start pulse during SHIFT is ignored.
    @(negedge clk);
    start = 1'b1;
    in_fixed = 16'h00C8;
    exp_q.push_back(mk(16'h0003, 4'd1, 4'd2, 4'd1, 4'd3, cyc + 12, 1'b0));
    $display("start: in_fixed=%04h (hold test)", in_fixed);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 3);
      in_fixed = (i == 3) ? 16'hFFFF : 16'h0000;
      check("hold_int", 32'(int_bcd), 32'h0005);
      check("hold_tenths", 32'(tenths), 32'd7);
      check("hold_hundredths", 32'(hundredths), 32'd5);
    end
    start = 1'b0;
    wait_idle();

    issue(16'h0001, 16'h0000, 4'd0, 4'd1, 4'd0, 4'd2);
    wait_idle();
    issue(16'hFFFF, 16'h1023, 4'd9, 4'd8, 4'd9, 4'd8);
    wait_idle();

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1;
    in_fixed = 16'h0040;
    exp_q.push_back(mk(16'h0001, 4'd0, 4'd0, 4'd0, 4'd0, cyc + 12, 1'b1));
    $display("start: in_fixed=0040 (start held)");
    @(negedge clk);
    in_fixed = 16'h0080;
    exp_q.push_back(mk(16'h0002, 4'd0, 4'd0, 4'd0, 4'd0, cyc + 22, 1'b0));
    repeat (11) @(negedge clk);
    start = 1'b0;
    $display("start released after second accept");
    wait_idle();

    // Reset in the fifth SHIFT cycle: everything clears, no done pulse.
    @(negedge clk);
    start = 1'b1;
    in_fixed = 16'h0170;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("reset asserted mid-conversion");
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_int", 32'(int_bcd), 32'(0));
    check("midrst_tenths", 32'(tenths), 32'(0));
    check("midrst_hundredths", 32'(hundredths), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'(0));

    issue(16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 4'd0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
